// File: rtl/dpram_port_arbiter_if.sv
// Requester-side command/response bus for the RAM port arbiter.
// Requester i occupies bit i of the strobes and slice i of the packed addr/data fields.
interface dpram_port_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = 8,
  parameter int DW   = 16
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_we;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/dpram_port_arbiter.sv
// Round-robin arbiter sharing one RAM channel between NREQ requesters.
// The arbiter registers the winning command onto the RAM port and returns read data two edges later.
module dpram_port_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 8,
  parameter int DW   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 arb_en,
  dpram_port_arbiter_if.slave  req_bus,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [AW-1:0]        ram_addr,
  output logic [DW-1:0]        ram_wdata,
  input  logic [DW-1:0]        ram_rdata
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW-1:0] PTR_RST = PW'(NREQ - 1);

  logic [PW-1:0]   ptr;
  logic [PW-1:0]   cand;
  logic [PW-1:0]   gnt_idx;
  logic            gnt_any;
  logic [NREQ-1:0] gnt_onehot;

  logic            s1_valid, s1_rd;
  logic [PW-1:0]   s1_id;
  logic            s2_valid, s2_rd;
  logic [PW-1:0]   s2_id;

  // Scan from lowest priority to highest so the last hit is the winner.
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = ptr;
    gnt_any    = 1'b0;
    cand       = '0;
    if (arb_en && rst_n) begin
      for (int k = NREQ; k >= 1; k--) begin
        cand = PW'((int'(ptr) + k) % NREQ);
        if (req_bus.req_valid[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = cand;
        end
      end
    end
    if (gnt_any) gnt_onehot[gnt_idx] = 1'b1;
  end

  assign req_bus.req_ready = gnt_onehot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr                <= PTR_RST;
      ram_en             <= 1'b0;
      ram_we             <= 1'b0;
      ram_addr           <= '0;
      ram_wdata          <= '0;
      s1_valid           <= 1'b0;
      s1_rd              <= 1'b0;
      s1_id              <= '0;
      s2_valid           <= 1'b0;
      s2_rd              <= 1'b0;
      s2_id              <= '0;
      req_bus.rsp_valid  <= '0;
      req_bus.rsp_rdata  <= '0;
    end else begin
      if (gnt_any) begin
        ptr       <= gnt_idx;
        ram_en    <= 1'b1;
        ram_we    <= req_bus.req_we[gnt_idx];
        ram_addr  <= req_bus.req_addr[gnt_idx*AW +: AW];
        ram_wdata <= req_bus.req_wdata[gnt_idx*DW +: DW];
        s1_valid  <= 1'b1;
        s1_rd     <= ~req_bus.req_we[gnt_idx];
        s1_id     <= gnt_idx;
      end else begin
        ram_en    <= 1'b0;
        ram_we    <= 1'b0;
        s1_valid  <= 1'b0;
      end

      s2_valid <= s1_valid;
      s2_rd    <= s1_rd;
      s2_id    <= s1_id;

      // RAM data for the s2 access is valid in this cycle; capture it for the issuer.
      req_bus.rsp_valid <= '0;
      if (s2_valid && s2_rd) begin
        req_bus.rsp_valid[s2_id] <= 1'b1;
        req_bus.rsp_rdata        <= ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Directed bench for dpram_port_arbiter with a read-first registered 256x16 RAM model.
module tb_dpram_port_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 8;
  localparam int DW   = 16;

  logic          clk;
  logic          rst_n;
  logic          arb_en;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic [DW-1:0] mem [256];

  int checks   = 0;
  int failures = 0;

  dpram_port_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  dpram_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .arb_en    (arb_en),
    .req_bus   (bus),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_en) begin
      ram_rdata <= mem[ram_addr];
      if (ram_we) mem[ram_addr] <= ram_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int i, input logic we, input logic [7:0] a, input logic [15:0] d);
    bus.req_we[i]            = we;
    bus.req_addr[i*AW +: AW] = a;
    bus.req_wdata[i*DW +: DW] = d;
    bus.req_valid[i]         = 1'b1;
  endtask

  initial begin
    rst_n         = 1'b0;
    arb_en        = 1'b1;
    bus.req_valid = 4'b1111;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    #2;
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_ram_en", ram_en, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    bus.req_valid = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // single requester: write then read back
    set_cmd(0, 1'b1, 8'h10, 16'hABCD);
    #1 chk("t1_wr_ready", bus.req_ready, 4'b0001);
    tick();
    bus.req_valid = '0;
    chk("t1_wr_ram_en", ram_en, 1);
    chk("t1_wr_ram_we", ram_we, 1);
    chk("t1_wr_addr", ram_addr, 8'h10);
    chk("t1_wr_data", ram_wdata, 16'hABCD);
    set_cmd(0, 1'b0, 8'h10, 16'h0000);
    #1 chk("t1_rd_ready", bus.req_ready, 4'b0001);
    tick();
    bus.req_valid = '0;
    chk("t1_rd_ram_en", ram_en, 1);
    chk("t1_rd_ram_we", ram_we, 0);
    tick();
    chk("t1_rsp_early", bus.rsp_valid, 0);
    tick();
    chk("t1_rsp_valid", bus.rsp_valid, 4'b0001);
    chk("t1_rsp_rdata", bus.rsp_rdata, 16'hABCD);
    tick();
    chk("t1_rsp_once", bus.rsp_valid, 0);

    // preload 0x00..0x03 through requester 3 so ptr ends at 3
    for (int k = 0; k < 4; k++) begin
      set_cmd(3, 1'b1, 8'(k), 16'(16'h1000 + k));
      tick();
    end
    bus.req_valid = '0;
    repeat (3) tick();

    // round robin: every requester reads its own address continuously
    for (int c = 0; c <= 10; c++) begin
      if (c < 8) begin
        for (int i = 0; i < 4; i++) set_cmd(i, 1'b0, 8'(i), 16'h0000);
      end else begin
        bus.req_valid = '0;
      end
      #1;
      chk($sformatf("rr_ready_c%0d", c), bus.req_ready, (c < 8) ? (32'd1 << (c % 4)) : 32'd0);
      if (c >= 3) begin
        chk($sformatf("rr_rsp_valid_c%0d", c), bus.rsp_valid, 32'd1 << ((c - 3) % 4));
        chk($sformatf("rr_rsp_rdata_c%0d", c), bus.rsp_rdata, 32'h1000 + ((c - 3) % 4));
      end else begin
        chk($sformatf("rr_rsp_idle_c%0d", c), bus.rsp_valid, 0);
      end
      tick();
    end
    bus.req_valid = '0;
    repeat (2) tick();

    // write-then-read hazard on 0x55
    set_cmd(1, 1'b1, 8'h55, 16'h1234);
    set_cmd(2, 1'b0, 8'h55, 16'h0000);
    #1 chk("hz_ready_wr", bus.req_ready, 4'b0010);
    tick();
    bus.req_valid[1] = 1'b0;
    #1 chk("hz_ready_rd", bus.req_ready, 4'b0100);
    tick();
    bus.req_valid = '0;
    tick();
    tick();
    chk("hz_rsp_valid", bus.rsp_valid, 4'b0100);
    chk("hz_rsp_rdata", bus.rsp_rdata, 16'h1234);
    repeat (2) tick();

    // arb_en gating with two reads in flight
    set_cmd(0, 1'b0, 8'h00, 16'h0000);
    set_cmd(1, 1'b0, 8'h01, 16'h0000);
    #1 chk("ae_ready0", bus.req_ready, 4'b0001);
    tick();
    #1 chk("ae_ready1", bus.req_ready, 4'b0010);
    tick();
    arb_en = 1'b0;
    #1 chk("ae_ready_off", bus.req_ready, 0);
    chk("ae_ram_en_last", ram_en, 1);
    tick();
    chk("ae_ram_en_idle1", ram_en, 0);
    chk("ae_rsp0_valid", bus.rsp_valid, 4'b0001);
    chk("ae_rsp0_rdata", bus.rsp_rdata, 16'h1000);
    tick();
    chk("ae_ram_en_idle2", ram_en, 0);
    chk("ae_rsp1_valid", bus.rsp_valid, 4'b0010);
    chk("ae_rsp1_rdata", bus.rsp_rdata, 16'h1001);
    tick();
    chk("ae_rsp_done", bus.rsp_valid, 0);
    chk("ae_ram_en_idle3", ram_en, 0);
    bus.req_valid = '0;
    arb_en = 1'b1;
    tick();

    // wrap: requester 3 on 0xFF, then requester 0 wins as ptr wraps 3->0
    set_cmd(3, 1'b1, 8'hFF, 16'hBEEF);
    #1 chk("wr_ready_w3", bus.req_ready, 4'b1000);
    tick();
    chk("wr_ram_addr_ff", ram_addr, 8'hFF);
    set_cmd(3, 1'b0, 8'hFF, 16'h0000);
    #1 chk("wr_ready_r3", bus.req_ready, 4'b1000);
    tick();
    set_cmd(0, 1'b0, 8'h02, 16'h0000);
    #1 chk("wr_ready_wrap", bus.req_ready, 4'b0001);
    tick();
    bus.req_valid = '0;
    tick();
    chk("wr_rsp3_valid", bus.rsp_valid, 4'b1000);
    chk("wr_rsp3_rdata", bus.rsp_rdata, 16'hBEEF);
    tick();
    chk("wr_rsp0_valid", bus.rsp_valid, 4'b0001);
    chk("wr_rsp0_rdata", bus.rsp_rdata, 16'h1002);
    repeat (2) tick();

    // reset one cycle after a read accept
    set_cmd(2, 1'b0, 8'h03, 16'h0000);
    #1 chk("mr_ready", bus.req_ready, 4'b0100);
    tick();
    bus.req_valid = '0;
    #3 rst_n = 1'b0;
    set_cmd(1, 1'b1, 8'h20, 16'h0001);
    #1;
    chk("mr_ready_rst", bus.req_ready, 0);
    chk("mr_ram_en", ram_en, 0);
    chk("mr_ram_addr", ram_addr, 0);
    chk("mr_ram_wdata", ram_wdata, 0);
    chk("mr_rsp_valid", bus.rsp_valid, 0);
    chk("mr_rsp_rdata", bus.rsp_rdata, 0);
    bus.req_valid = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("mr_no_rsp_c%0d", c), bus.rsp_valid, 0);
    end
    set_cmd(0, 1'b1, 8'h30, 16'h0002);
    set_cmd(1, 1'b1, 8'h31, 16'h0003);
    #1 chk("mr_first_grant", bus.req_ready, 4'b0001);
    tick();
    bus.req_valid = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("mr_wr_no_rsp_c%0d", c), bus.rsp_valid, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
